// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage, register file and the decode/EX logic
// that consumes the same result_src encoding.
package wb_regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREGS);
    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_mem.sv
// 32x32 integer register storage: one write port, two combinational read ports,
// x0 hard-wired to zero on both the write and read side.
module wb_regfile_mem
    import wb_regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]      rdata1_c,
    output logic [XLEN-1:0]      rdata2_c
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next-state of the array; entry 0 is pinned to zero so it can never hold data.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Index 0 reads as zero regardless of what the storage holds.
    always_comb begin
        rdata1_c = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2_c = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule : wb_regfile_mem

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register file commit, decode read ports and retired-
// instruction counter. Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_w,
    input  logic                 reg_write_w,
    input  logic [1:0]           result_src_w,
    input  logic [XLEN-1:0]      alu_result_w,
    input  logic [XLEN-1:0]      read_data_w,
    input  logic [XLEN-1:0]      pc_plus4_w,
    input  logic [XLEN-1:0]      ext_imm_w,
    input  logic [REG_IDX_W-1:0] rd_w,
    input  logic [REG_IDX_W-1:0] rs1_d,
    input  logic [REG_IDX_W-1:0] rs2_d,
    output logic [XLEN-1:0]      rd1_d,
    output logic [XLEN-1:0]      rd2_d,
    output logic [XLEN-1:0]      result_w,
    output logic                 wr_en_w,
    output logic [CNT_W-1:0]     instret
);

    logic [XLEN-1:0]  rd1_raw;
    logic [XLEN-1:0]  rd2_raw;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    always_comb begin
        result_w = alu_result_w;
        unique case (result_src_e'(result_src_w))
            RES_ALU: result_w = alu_result_w;
            RES_MEM: result_w = read_data_w;
            RES_PC4: result_w = pc_plus4_w;
            RES_IMM: result_w = ext_imm_w;
        endcase
    end

    // Gating by valid_w keeps bubbles (possibly with junk controls) from committing.
    assign wr_en_w = valid_w & reg_write_w & (rd_w != '0);

    wb_regfile_mem u_mem (
        .clk      (clk),
        .rst_n    (rst),
        .we       (wr_en_w),
        .waddr    (rd_w),
        .wdata    (result_w),
        .raddr1   (rs1_d),
        .raddr2   (rs2_d),
        .rdata1_c (rd1_raw),
        .rdata2_c (rd2_raw)
    );

`ifdef WB_BYPASS_EN
    // wr_en_w already excludes rd_w == 0, so x0 is never forwarded; reset forces reads to 0.
    always_comb begin
        rd1_d = rd1_raw;
        rd2_d = rd2_raw;
        if (rst && wr_en_w && (rs1_d == rd_w)) begin
            rd1_d = result_w;
        end
        if (rst && wr_en_w && (rs2_d == rd_w)) begin
            rd2_d = result_w;
        end
    end
`else
    assign rd1_d = rd1_raw;
    assign rd2_d = rd2_raw;
`endif

    always_comb begin
        instret_d = instret_q;
        if (valid_w) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile against an array-based architectural model.
module tb_wb_regfile;

    localparam int unsigned TB_CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_w, reg_write_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus4_w, ext_imm_w;
    logic [4:0]  rd_w, rs1_d, rs2_d;
    logic [31:0] rd1_d, rd2_d, result_w;
    logic        wr_en_w;
    logic [TB_CNT_W-1:0] instret;

    wb_regfile #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_w(valid_w), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w), .ext_imm_w(ext_imm_w),
        .rd_w(rd_w), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .result_w(result_w), .wr_en_w(wr_en_w), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic        wen;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_regs [32];
    int unsigned m_cnt;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: outputs are combinational, so they are settled by the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd1_d", rd1_d, e.rd1);
            chk("rd2_d", rd2_d, e.rd2);
            chk("result_w", result_w, e.res);
            chk("wr_en_w", 32'(wr_en_w), 32'(e.wen));
            chk("instret", 32'(instret), e.cnt);
        end
    end

    function automatic logic [31:0] read_model(input logic [4:0] rs, input bit wen,
                                               input logic [4:0] rd, input logic [31:0] res,
                                               input bit rstv);
        if (rs == 0) return 32'h0;
        if (BYPASS && rstv && wen && rs == rd) return res;
        return m_regs[rs];
    endfunction

    // Drive one cycle of inputs just after the rising edge, predict outputs, then
    // advance the model to the state it will have after the next rising edge.
    task automatic apply(input bit rstv, input bit v, input bit rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t        e;
        logic [31:0] res;
        bit          wen;
        @(posedge clk);
        #1;
        rst = rstv; valid_w = v; reg_write_w = rw; result_src_w = src;
        alu_result_w = alu; read_data_w = mem; pc_plus4_w = pc4; ext_imm_w = imm;
        rd_w = rd; rs1_d = rs1; rs2_d = rs2;
        if (!rstv) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_cnt = 0;
        end
        res = (src == 2'd0) ? alu : (src == 2'd1) ? mem : (src == 2'd2) ? pc4 : imm;
        wen = v && rw && (rd != 0);
        e.res = res;
        e.wen = wen;
        e.rd1 = read_model(rs1, wen, rd, res, rstv);
        e.rd2 = read_model(rs2, wen, rd, res, rstv);
        e.cnt = m_cnt;
        exp_q.push_back(e);
        if (rstv) begin
            if (wen) m_regs[rd] = res;
            if (v) m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
        end
    endtask

    task automatic idle_read(input logic [4:0] rs1, input logic [4:0] rs2);
        apply(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, rs1, rs2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1);
    end

    initial begin
        rst = 1'b0; valid_w = 1'b0; reg_write_w = 1'b0; result_src_w = 2'd0;
        alu_result_w = '0; read_data_w = '0; pc_plus4_w = '0; ext_imm_w = '0;
        rd_w = '0; rs1_d = '0; rs2_d = '0;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_cnt = 0;

        // Reset state, then write x5 and observe it
        apply(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        apply(1'b1, 1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 5'd5, 5'd0, 5'd0);
        idle_read(5'd5, 5'd5);
        // Mid-run reset with a coinciding write that must be dropped
        apply(1'b0, 1'b1, 1'b1, 2'd0, 32'h5555AAAA, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
        idle_read(5'd5, 5'd0);

        // Result select sweep onto x7
        for (int s = 0; s < 4; s++)
            apply(1'b1, 1'b1, 1'b1, 2'(s), 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 5'd7, 5'd0);
        idle_read(5'd7, 5'd7);

        // x0 protection and bubble
        apply(1'b1, 1'b1, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0);
        apply(1'b1, 1'b0, 1'b1, 2'd0, 32'hAA, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3);
        idle_read(5'd3, 5'd0);

        // Same-cycle RAW on x9
        apply(1'b1, 1'b1, 1'b1, 2'd1, 32'h0, 32'h00000BAD, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0);
        apply(1'b1, 1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h1234, 5'd9, 5'd9, 5'd9);
        idle_read(5'd9, 5'd9);

        // Counter wrap: 20 consecutive valid non-writing slots cross all-ones -> 0
        for (int k = 0; k < 20; k++)
            apply(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd7);

        // Randomized traffic biased toward a small register window for RAW hits
        for (int k = 0; k < 400; k++) begin
            apply(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom));
        end

        repeat (2) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_regfile
